// File: rtl/cdc_fifo_pkg.sv
// Shared constants and pointer helpers for the async CDC FIFO.
// Pointers carry one extra MSB beyond the address so full and empty differ.
package cdc_fifo_pkg;

  localparam int ADDR_W_DEF       = 4;
  localparam int AFULL_MARGIN_DEF = 2;

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  // Width-agnostic: callers zero-extend in and size-cast the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin_conv.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR reduction of the Gray code shifted down by its index.
module gray_to_bin_conv #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] gray,
  output logic [SIZE-1:0] bin
);

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer/status controller for the async FIFO: Gray write pointer,
// 2-flop read-pointer synchronizer, and registered full / almost-full / level.
module fifo_wptr_full_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AFULL_MARGIN = AFULL_MARGIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wfull,
  output logic              wafull,
  output logic [ADDR_W:0]   wlevel
);

  localparam int PTR_W = ptr_width(ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_MARGIN);

  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("fifo_wptr_full_ctrl: ADDR_W must be at least 2");
  end
  if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
    $error("fifo_wptr_full_ctrl: AFULL_MARGIN out of range");
  end

  logic [PTR_W-1:0] wbin_q,   wbin_d;
  logic [PTR_W-1:0] wgray_q,  wgray_d;
  logic [PTR_W-1:0] rq1_q,    rq1_d;
  logic [PTR_W-1:0] rq2_q,    rq2_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             wfull_q,  wfull_d;
  logic             wafull_q, wafull_d;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] full_gray_s;

  gray_to_bin_conv #(
    .SIZE (PTR_W)
  ) u_rq2_g2b (
    .gray (rq2_q),
    .bin  (rbin_s)
  );

  assign wen = winc & ~wfull_q;

  always_comb begin
    rq1_d   = rptr_gray_async;
    rq2_d   = rq1_q;
    wbin_d  = wbin_q + PTR_W'(wen);
    wgray_d = PTR_W'(bin2gray(32'(wbin_d)));
    // Full when the write pointer sits one lap ahead: Gray form flips the top two bits.
    full_gray_s = {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]};
    wfull_d  = (wgray_d == full_gray_s);
    wlevel_d = wbin_d - rbin_s;
    wafull_d = (wlevel_d >= AFULL_LVL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rq1_q    <= '0;
      rq2_q    <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rq1_q    <= rq1_d;
      rq2_q    <= rq2_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

  assign waddr     = wbin_q[ADDR_W-1:0];
  assign wptr_gray = wgray_q;
  assign wlevel    = wlevel_q;
  assign wfull     = wfull_q;
  assign wafull    = wafull_q;

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Scoreboard bench for fifo_wptr_full_ctrl (ADDR_W=4, AFULL_MARGIN=2).
module tb_fifo_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic [4:0] rptr_gray_async;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;

  fifo_wptr_full_ctrl #(
    .ADDR_W       (4),
    .AFULL_MARGIN (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .winc            (winc),
    .wen             (wen),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .rptr_gray_async (rptr_gray_async),
    .wfull           (wfull),
    .wafull          (wafull),
    .wlevel          (wlevel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] waddr;
    logic [4:0] gray;
    logic [4:0] level;
    logic       full;
    logic       afull;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model kept as integer counts: write count and synchronized read count.
  int   m_wb = 0, m_r1 = 0, m_r2 = 0, m_lvl = 0;
  logic m_full = 1'b0, m_afull = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input int rbn);
    exp_t       e;
    exp_t       got;
    int         rb;
    int         wbn;
    logic       acc;
    logic [4:0] prev_gray;
    rb              = rbn & 31;
    rst             = r;
    winc            = w;
    rptr_gray_async = 5'(rb ^ (rb >> 1));
    #1;
    if (!r) chk("wen", 32'(wen), 32'(w & ~m_full));
    acc = w && !m_full && !r;
    if (r) begin
      m_wb = 0; m_r1 = 0; m_r2 = 0; m_lvl = 0; m_full = 1'b0; m_afull = 1'b0;
    end else begin
      wbn     = (m_wb + (acc ? 1 : 0)) & 31;
      m_lvl   = (wbn - m_r2) & 31;
      m_full  = (m_lvl == 16);
      m_afull = (m_lvl >= 14);
      m_r2    = m_r1;
      m_r1    = rb;
      m_wb    = wbn;
    end
    e.waddr = 4'(m_wb & 15);
    e.gray  = 5'(m_wb ^ (m_wb >> 1));
    e.level = 5'(m_lvl);
    e.full  = m_full;
    e.afull = m_afull;
    sb.push_back(e);
    prev_gray = wptr_gray;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(0), 32'(1));
    end else begin
      got = sb.pop_front();
      chk("waddr",  32'(waddr),     32'(got.waddr));
      chk("gray",   32'(wptr_gray), 32'(got.gray));
      chk("wlevel", 32'(wlevel),    32'(got.level));
      chk("wfull",  32'(wfull),     32'(got.full));
      chk("wafull", 32'(wafull),    32'(got.afull));
    end
    if (!r) chk("gray_step", 32'($countones(prev_gray ^ wptr_gray)), 32'(acc));
    chk("full_vs_lvl16", 32'(wfull), 32'(wlevel == 5'd16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         pre_wb;
    int         wrapped;
    logic [4:0] g_before;
    rst = 1'b1; winc = 1'b0; rptr_gray_async = '0;

    // Reset with a write and a non-zero read pointer presented.
    step(1'b1, 1'b1, 25);
    chk("rst_waddr", 32'(waddr), 32'(0));
    chk("rst_gray",  32'(wptr_gray), 32'(0));
    chk("rst_lvl",   32'(wlevel), 32'(0));
    chk("rst_full",  32'(wfull), 32'(0));
    chk("rst_afull", 32'(wafull), 32'(0));
    rst = 1'b0; winc = 1'b1; #1;
    chk("rst_wen", 32'(wen), 32'(1));

    // Fill to full with the reader parked at zero.
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 0);
      if (i == 13) chk("afull13", 32'(wafull), 32'(0));
      if (i == 14) begin
        chk("afull14", 32'(wafull), 32'(1));
        chk("lvl14",   32'(wlevel), 32'(14));
      end
      if (i == 15) chk("full15", 32'(wfull), 32'(0));
    end
    chk("full16",    32'(wfull), 32'(1));
    chk("lvl16",     32'(wlevel), 32'(16));
    chk("gray_full", 32'(wptr_gray), 32'(5'b11000));

    // Overflow attempts are refused and state holds.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0);
    chk("ovf_gray", 32'(wptr_gray), 32'(5'b11000));
    chk("ovf_lvl",  32'(wlevel), 32'(16));

    // One read becomes visible two edges after the pointer changes.
    step(1'b0, 1'b0, 1);
    chk("drain_k",  32'(wfull), 32'(1));
    step(1'b0, 1'b0, 1);
    chk("drain_k1", 32'(wfull), 32'(1));
    step(1'b0, 1'b0, 1);
    chk("drain_k2",     32'(wfull), 32'(0));
    chk("drain_k2_lvl", 32'(wlevel), 32'(15));
    step(1'b0, 1'b1, 1);
    chk("drain_wr_lvl", 32'(wlevel), 32'(16));

    // Reader trails by three entries across a pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, (m_wb - 3) & 31);
    chk("pre_wrap_full", 32'(wfull), 32'(0));
    wrapped = 0;
    for (int i = 0; i < 40; i++) begin
      pre_wb   = m_wb;
      g_before = wptr_gray;
      step(1'b0, 1'b1, (m_wb - 3) & 31);
      chk("wrap_no_full", 32'(wfull), 32'(0));
      if (pre_wb == 31) begin
        chk("wrap_from", 32'(g_before), 32'(5'b10000));
        chk("wrap_to",   32'(wptr_gray), 32'(0));
        wrapped++;
      end
    end
    chk("wrap_seen", 32'(wrapped), 32'(1));

    // Reset in the middle of a fill drops the concurrent write.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 0);
    chk("mid_waddr9", 32'(waddr), 32'(9));
    step(1'b1, 1'b1, 0);
    chk("mid_rst_waddr", 32'(waddr), 32'(0));
    chk("mid_rst_gray",  32'(wptr_gray), 32'(0));
    chk("mid_rst_lvl",   32'(wlevel), 32'(0));
    chk("mid_rst_full",  32'(wfull), 32'(0));
    chk("mid_rst_afull", 32'(wafull), 32'(0));
    step(1'b0, 1'b1, 0);
    chk("post_waddr", 32'(waddr), 32'(1));
    chk("post_gray",  32'(wptr_gray), 32'(5'b00001));

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
